day3_line_sender: RTL and testbench

- Walks the day-3 input ROM and delivers one rucksack line at a time to the solver over a valid/ready byte stream.
- Each byte is tagged with the compartment half it belongs to, and the last byte of each line is flagged.
- Buffers each line internally so the length, and therefore the half split, is known before the first byte is sent.
- Sits between the input ROM and the priority comparator/summer. Drives the ROM address; the solver is the stream sink.

---
 rtl/day3_line_sender.sv | 192 +++++++++++++++++++
 tb/tb_day3_line_sender.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/day3_line_sender.sv
// day3_line_sender
// Walks the day-3 input ROM from address 0 and feeds one rucksack line at a
// time to the solver over a valid/ready byte stream. Each line is buffered
// first, so its length (and therefore its compartment split) is known before
// the first byte leaves.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start        one-cycle pulse, begins a pass (honoured in IDLE/DONE only)
//   rom_addr     ROM read address; rom_data is valid one cycle later
//   m_valid/m_ready/m_data  byte stream to the solver
//   m_half       0 = first compartment, 1 = second compartment
//   m_last       last byte of the current line
//   line_len     length of the line being sent
//   line_count   lines fully sent (saturating)
//   overflow     sticky, a line exceeded MAX_LINE bytes
//   done         pass complete, held until next start or reset
//
// Build option: define DAY3_CRLF_STRIP_EN to drop 0x0D bytes while filling.
module day3_line_sender #(
   parameter int ADDR_W   = 12,
   parameter int MAX_LINE = 64,
   parameter int LEN_W    = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0]        m_data,
   output logic              m_half,
   output logic              m_last,
   output logic [LEN_W-1:0]  line_len,
   output logic [15:0]       line_count,
   output logic              overflow,
   output logic              done
);

   localparam int                PTR_W    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
   localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
   localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LINE);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FILL, S_SEND, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              eof_q, eof_d;     // terminating line of the pass is buffered
   logic              top_q, top_d;     // rom_data comes from the last ROM address

   logic [7:0]        buf_q [MAX_LINE];
   logic              wr_en;

   logic is_nl, is_eof, is_cr, at_top;

   assign is_nl  = (rom_data == 8'h0A);
   assign is_eof = top_q || (rom_data == 8'h00);
   assign at_top = (addr_q == ADDR_TOP);
`ifdef DAY3_CRLF_STRIP_EN
   assign is_cr  = (rom_data == 8'h0D);
`else
   assign is_cr  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      eof_d   = eof_q;
      top_d   = top_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH;
               addr_d  = '0;
               ptr_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               eof_d   = 1'b0;
               top_d   = 1'b0;
            end
         end
         S_FETCH: begin
            // Read issued this cycle lands in FILL; never step past the top.
            state_d = S_FILL;
            top_d   = at_top;
            if (!at_top) addr_d = addr_q + 1'b1;
         end
         S_FILL: begin
            // Default: keep streaming reads.
            top_d = at_top;
            if (!at_top) addr_d = addr_q + 1'b1;
            if (is_eof) begin
               if (ptr_q != '0) begin
                  len_d   = ptr_q;
                  idx_d   = '0;
                  eof_d   = 1'b1;
                  state_d = S_SEND;
               end else begin
                  state_d = S_DONE;
               end
            end else if (is_nl) begin
               if (ptr_q != '0) begin
                  // addr_q already points at the next unread byte; hold it
                  // so FETCH re-primes from there after SEND.
                  addr_d  = addr_q;
                  top_d   = top_q;
                  len_d   = ptr_q;
                  idx_d   = '0;
                  state_d = S_SEND;
               end
            end else if (is_cr) begin
               // dropped
            end else if (ptr_q == LEN_MAX) begin
               ovf_d = 1'b1;
            end else begin
               wr_en = 1'b1;
               ptr_d = ptr_q + LEN_ONE;
            end
         end
         S_SEND: begin
            if (m_ready) begin
               if (idx_q == len_q - LEN_ONE) begin
                  if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                  ptr_d   = '0;
                  idx_d   = '0;
                  state_d = eof_q ? S_DONE : S_FETCH;
               end else begin
                  idx_d = idx_q + LEN_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         eof_q   <= 1'b0;
         top_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         eof_q   <= eof_d;
         top_q   <= top_d;
      end
   end

   // Line buffer carries no reset; its contents are only read after a fill.
   always_ff @(posedge clk) begin
      if (wr_en) buf_q[ptr_q[PTR_W-1:0]] <= rom_data;
   end

   logic sending;
   assign sending    = (state_q == S_SEND);
   assign m_valid    = sending;
   assign m_data     = sending ? buf_q[idx_q[PTR_W-1:0]] : 8'h00;
   // Odd lengths put the extra byte in the second compartment.
   assign m_half     = sending && (idx_q >= (len_q >> 1));
   assign m_last     = sending && (idx_q == len_q - LEN_ONE);
   assign rom_addr   = addr_q;
   assign line_len   = len_q;
   assign line_count = cnt_q;
   assign overflow   = ovf_q;
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_day3_line_sender.sv
module tb_day3_line_sender;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [7:0]  m_data;
   logic        m_half;
   logic        m_last;
   logic [6:0]  line_len;
   logic [15:0] line_count;
   logic        overflow;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [4096];

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= mem[rom_addr];

   day3_line_sender dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_half(m_half), .m_last(m_last), .line_len(line_len),
      .line_count(line_count), .overflow(overflow), .done(done)
   );

   typedef struct {
      string rom;       // ROM image (zero-filled after it)
      bit    toggle;    // m_ready alternates 1/0 when set
      string data;      // expected stream bytes
      string half;      // expected m_half per byte ("0"/"1")
      string last;      // expected m_last per byte
      int    lines;     // expected line_count at done
      bit    ovf;       // expected overflow at done
      int    last_len;  // expected line_len on the final byte
   } case_t;

   logic [7:0] got_d [$];
   logic       got_h [$];
   logic       got_l [$];
   logic [6:0] got_len [$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic load(input string s);
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      for (int i = 0; i < s.len(); i++) mem[i] = s[i];
   endtask

   // Pulse start, stream until done (bounded), collecting handshaken bytes.
   task automatic run(input bit toggle);
      bit   stall_prev = 0;
      logic [7:0] d_prev = 0;
      logic h_prev = 0, l_prev = 0;
      int   cyc = 0;
      got_d.delete(); got_h.delete(); got_l.delete(); got_len.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (!done && cyc < 3000) begin
         m_ready = toggle ? cyc[0] : 1'b1;
         if (stall_prev) begin
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_data", int'(m_data), int'(d_prev));
            chk("hold_half_last", int'({m_half, m_last}), int'({h_prev, l_prev}));
         end
         if (m_valid && m_ready) begin
            got_d.push_back(m_data); got_h.push_back(m_half);
            got_l.push_back(m_last); got_len.push_back(line_len);
         end
         stall_prev = m_valid && !m_ready;
         d_prev = m_data; h_prev = m_half; l_prev = m_last;
         cyc++;
         @(negedge clk);
      end
      m_ready = 1'b0;
      chk("done_reached", int'(done), 1);
   endtask

   task automatic compare(input case_t c, input int n);
      chk($sformatf("c%0d_nbytes", n), got_d.size(), c.data.len());
      for (int i = 0; i < c.data.len() && i < got_d.size(); i++) begin
         chk($sformatf("c%0d_data[%0d]", n, i), int'(got_d[i]), int'(c.data[i]));
         chk($sformatf("c%0d_half[%0d]", n, i), int'(got_h[i]), int'(c.half[i] == "1"));
         chk($sformatf("c%0d_last[%0d]", n, i), int'(got_l[i]), int'(c.last[i] == "1"));
      end
      if (got_len.size() > 0)
         chk($sformatf("c%0d_line_len", n), int'(got_len[got_len.size()-1]), c.last_len);
      chk($sformatf("c%0d_line_count", n), int'(line_count), c.lines);
      chk($sformatf("c%0d_overflow", n), int'(overflow), int'(c.ovf));
      chk($sformatf("c%0d_m_valid_done", n), int'(m_valid), 0);
   endtask

   initial begin
      case_t tbl [6];
      case_t rc;
      string lng, lng_exp, lng_h, lng_l;
      int    cyc;

      // Overflow line: 70 bytes, only the first 64 are delivered.
      lng = ""; lng_exp = ""; lng_h = ""; lng_l = "";
      for (int i = 0; i < 70; i++) begin
         string ch;
         ch = " ";
         ch[0] = 8'(65 + (i % 26));
         lng = {lng, ch};
         if (i < 64) begin
            lng_exp = {lng_exp, ch};
            lng_h   = {lng_h, (i >= 32) ? "1" : "0"};
            lng_l   = {lng_l, (i == 63) ? "1" : "0"};
         end
      end

      tbl[0] = '{"vJrwpWtwJgWrhcsFMMfFFhFp\n", 1'b0, "vJrwpWtwJgWrhcsFMMfFFhFp",
                 "000000000000111111111111", "000000000000000000000001", 1, 1'b0, 24};
      tbl[1] = '{"ab\n\nCd\n", 1'b1, "abCd", "0101", "0101", 2, 1'b0, 2};
      tbl[2] = '{"abc", 1'b0, "abc", "011", "001", 1, 1'b0, 3};
`ifdef DAY3_CRLF_STRIP_EN
      tbl[3] = '{"ab\015\n", 1'b0, "ab", "01", "01", 1, 1'b0, 2};
`else
      tbl[3] = '{"ab\015\n", 1'b0, "ab\015", "011", "001", 1, 1'b0, 3};
`endif
      tbl[4] = '{{lng, "\nxy\n"}, 1'b0, {lng_exp, "xy"}, {lng_h, "01"}, {lng_l, "01"},
                 2, 1'b1, 2};
      tbl[5] = '{"\n\n", 1'b0, "", "", "", 0, 1'b0, 0};

      // Reset state.
      load("");
      repeat (3) @(negedge clk);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_line_count", int'(line_count), 0);
      chk("rst_line_len", int'(line_len), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_data_half_last", int'({m_data, m_half, m_last}), 0);
      rst_n = 1'b1;

      for (int n = 0; n < 6; n++) begin
         load(tbl[n].rom);
         run(tbl[n].toggle);
         compare(tbl[n], n);
      end

      // Reset while the second line is being sent.
      load("ab\ncd\n");
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      m_ready = 1'b1;
      cyc = 0;
      while (!(m_valid && line_count == 16'd1) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_line2_reached", int'(m_valid && line_count == 16'd1), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_m_valid", int'(m_valid), 0);
      chk("midrst_line_count", int'(line_count), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_rom_addr", int'(rom_addr), 0);
      @(negedge clk) rst_n = 1'b1;
      m_ready = 1'b0;
      rc = '{"ab\ncd\n", 1'b0, "abcd", "0101", "0101", 2, 1'b0, 2};
      run(rc.toggle);
      compare(rc, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
